// File: rtl/types_amba_pkg.sv
// rtl/types_amba_pkg.sv - shared AXI4 system bus types, constants and master FSM states
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS  = 32;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
    localparam int CFG_SYSBUS_ID_BITS    = 4;
    localparam int CFG_SYSBUS_USER_BITS  = 1;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    typedef struct packed {
        logic                             aw_valid;
        axi4_metadata_type                aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_metadata_type                ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                             aw_ready;
        logic                             w_ready;
        logic                             b_valid;
        logic [1:0]                       b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
        logic                             ar_ready;
        logic                             r_valid;
        logic [1:0]                       r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
        logic                             r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
    } axi4_master_in_type;

    typedef enum logic [2:0] {
        AXI_MST_IDLE,
        AXI_MST_RADDR,
        AXI_MST_RDATA,
        AXI_MST_WRITE,
        AXI_MST_WRESP,
        AXI_MST_RESP
    } axi4_master_state_type;

    // States during which the bus owes us a handshake and the watchdog runs.
    function automatic logic mst_state_active(axi4_master_state_type s);
        return (s == AXI_MST_RADDR) || (s == AXI_MST_RDATA) ||
               (s == AXI_MST_WRITE) || (s == AXI_MST_WRESP);
    endfunction

endpackage

// File: rtl/axi4_simple_master.sv
// rtl/axi4_simple_master.sv - single-outstanding, single-beat AXI4 initiator with watchdog
module axi4_simple_master
    import types_amba_pkg::*;
#(
    parameter int timeout_cycles = 1024,
    parameter int xid            = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
    input  logic [2:0]                       i_req_size,
    input  logic                             i_req_write,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
    output logic                             o_resp_valid,
    input  logic                             i_resp_ready,
    output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
    output logic                             o_resp_err,
    input  axi4_master_in_type               i_xmsti,
    output axi4_master_out_type              o_xmsto
);

    axi4_master_state_type state_q, state_d;

    logic [CFG_SYSBUS_ADDR_BITS-1:0]  addr_q;
    logic [2:0]                       size_q;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata_q;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb_q;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  rdata_q, rdata_d;
    logic                             err_q, err_d;
    logic                             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0]                      timer_q, timer_d;

    logic req_ready_q, resp_valid_q;
    logic ar_valid_q, aw_valid_q, w_valid_q, r_ready_q, b_ready_q;

    logic req_accept, ar_hs, aw_hs, w_hs, r_hs, b_hs, progress, expired;
    logic unused_in;

    assign req_accept = (state_q == AXI_MST_IDLE) && req_ready_q && i_req_valid;
    assign ar_hs      = ar_valid_q && i_xmsti.ar_ready;
    assign aw_hs      = aw_valid_q && i_xmsti.aw_ready;
    assign w_hs       = w_valid_q && i_xmsti.w_ready;
    assign r_hs       = r_ready_q && i_xmsti.r_valid;
    assign b_hs       = b_ready_q && i_xmsti.b_valid;
    assign progress   = ar_hs || aw_hs || w_hs || r_hs || b_hs;
    assign expired    = (timeout_cycles != 0) && !progress &&
                        (timer_q == 32'(timeout_cycles - 1));

    assign unused_in = ^{i_xmsti.r_last, i_xmsti.r_id, i_xmsti.r_user, i_xmsti.b_id,
                         i_xmsti.b_user, i_xmsti.r_resp[0], i_xmsti.b_resp[0]};

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        timer_d   = timer_q;
        unique case (state_q)
            AXI_MST_IDLE: begin
                timer_d   = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req_accept)
                    state_d = i_req_write ? AXI_MST_WRITE : AXI_MST_RADDR;
            end
            AXI_MST_RADDR: if (ar_hs) state_d = AXI_MST_RDATA;
            AXI_MST_RDATA: if (r_hs) begin
                rdata_d = i_xmsti.r_data;
                err_d   = i_xmsti.r_resp[1];
                state_d = AXI_MST_RESP;
            end
            AXI_MST_WRITE: begin
                // AW and W may complete in either order or together.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) state_d = AXI_MST_WRESP;
            end
            AXI_MST_WRESP: if (b_hs) begin
                rdata_d = '0;
                err_d   = i_xmsti.b_resp[1];
                state_d = AXI_MST_RESP;
            end
            AXI_MST_RESP: if (i_resp_ready) state_d = AXI_MST_IDLE;
            default: state_d = AXI_MST_IDLE;
        endcase
        if (mst_state_active(state_q)) begin
            if (progress) begin
                timer_d = '0;
            end else if (expired) begin
                state_d = AXI_MST_RESP;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end
    end

    // Handshake outputs are registered from the next state, so they all read 0 right after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= AXI_MST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            timer_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            ar_valid_q   <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            b_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            timer_q      <= timer_d;
            req_ready_q  <= (state_d == AXI_MST_IDLE);
            resp_valid_q <= (state_d == AXI_MST_RESP);
            ar_valid_q   <= (state_d == AXI_MST_RADDR);
            aw_valid_q   <= (state_d == AXI_MST_WRITE) && !aw_done_d;
            w_valid_q    <= (state_d == AXI_MST_WRITE) && !w_done_d;
            r_ready_q    <= (state_d == AXI_MST_RDATA) || (state_d == AXI_MST_IDLE);
            b_ready_q    <= (state_d == AXI_MST_WRESP) || (state_d == AXI_MST_IDLE);
            if (req_accept) begin
                addr_q  <= i_req_addr;
                size_q  <= i_req_size;
                wdata_q <= i_req_wdata;
                wstrb_q <= i_req_wstrb;
            end
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

    always_comb begin
        o_xmsto               = '0;
        o_xmsto.aw_valid      = aw_valid_q;
        o_xmsto.aw_bits.addr  = addr_q;
        o_xmsto.aw_bits.size  = size_q;
        o_xmsto.aw_bits.burst = AXI_BURST_INCR;
        o_xmsto.aw_id         = CFG_SYSBUS_ID_BITS'(xid);
        o_xmsto.w_valid       = w_valid_q;
        o_xmsto.w_data        = wdata_q;
        o_xmsto.w_strb        = wstrb_q;
        o_xmsto.w_last        = 1'b1;
        o_xmsto.b_ready       = b_ready_q;
        o_xmsto.ar_valid      = ar_valid_q;
        o_xmsto.ar_bits.addr  = addr_q;
        o_xmsto.ar_bits.size  = size_q;
        o_xmsto.ar_bits.burst = AXI_BURST_INCR;
        o_xmsto.ar_id         = CFG_SYSBUS_ID_BITS'(xid);
        o_xmsto.r_ready       = r_ready_q;
    end

endmodule

// File: tb/tb_axi4_simple_master.sv
// tb/tb_axi4_simple_master.sv - directed self-checking bench for axi4_simple_master
module tb_axi4_simple_master;
    import types_amba_pkg::*;

    logic                             clk;
    logic                             rst;
    logic                             req_valid;
    logic                             req_ready;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  req_addr;
    logic [2:0]                       req_size;
    logic                             req_write;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  req_wdata;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] req_wstrb;
    logic                             resp_valid;
    logic                             resp_ready;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  resp_rdata;
    logic                             resp_err;
    axi4_master_in_type               xmsti;
    axi4_master_out_type              xmsto;

    int passes = 0;
    int total  = 0;
    int aw_cnt, w_cnt, n;

    axi4_simple_master #(.timeout_cycles(16), .xid(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_size   (req_size),
        .i_req_write  (req_write),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .i_xmsti      (xmsti),
        .o_xmsto      (xmsto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] bus_flags();
        return {xmsto.ar_valid, xmsto.aw_valid, xmsto.w_valid, xmsto.r_ready, xmsto.b_ready};
    endfunction

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = 3'd3;
        req_wdata = wdata;
        req_wstrb = wstrb;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] data);
        issue(1'b0, addr, '0, '0);
        check({tag, "_pre_arvalid"}, 64'(xmsto.ar_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        check({tag, "_arvalid_lat1"}, 64'(xmsto.ar_valid), 64'd1);
        check({tag, "_araddr"}, 64'(xmsto.ar_bits.addr), 64'(addr));
        check({tag, "_ar_len_size_burst_id"},
              64'({xmsto.ar_bits.len, xmsto.ar_bits.size, xmsto.ar_bits.burst, xmsto.ar_id}),
              64'({8'd0, 3'd3, 2'b01, 4'd5}));
        xmsti.ar_ready = 1'b1;
        tick();
        xmsti.ar_ready = 1'b0;
        check({tag, "_rdata_phase"}, 64'({xmsto.ar_valid, xmsto.r_ready}), 64'b01);
        xmsti.r_valid = 1'b1;
        xmsti.r_data  = data;
        xmsti.r_resp  = AXI_RESP_OKAY;
        tick();
        xmsti.r_valid = 1'b0;
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_rdata"}, resp_rdata, data);
        check({tag, "_err"}, 64'(resp_err), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_back_idle"}, 64'({resp_valid, req_ready}), 64'b01);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_write = 1'b0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        xmsti = '0;
        tick();
        tick();
        check("reset_flags", 64'(bus_flags()), 64'd0);
        check("reset_ready_resp", 64'({req_ready, resp_valid}), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready_drain", 64'({req_ready, bus_flags()}), 64'b1_00011);

        do_read("rd1", 32'h0000_1000, 64'hDEADBEEF_CAFEF00D);

        // Write where W is taken three cycles ahead of AW.
        issue(1'b1, 32'h20, 64'h1122334455667788, 8'h0F);
        tick();
        req_valid = 1'b0;
        check("wr1_valids", 64'({xmsto.aw_valid, xmsto.w_valid, xmsto.w_last}), 64'b111);
        check("wr1_wdata", xmsto.w_data, 64'h1122334455667788);
        check("wr1_wstrb_addr", 64'({xmsto.w_strb, xmsto.aw_bits.addr}), {32'h0F, 32'h20});
        aw_cnt = 0;
        w_cnt  = 0;
        for (int k = 0; k < 4; k++) begin
            xmsti.w_ready  = (k == 0);
            xmsti.aw_ready = (k == 3);
            if (k == 1) check("wr1_w_dropped", 64'({xmsto.aw_valid, xmsto.w_valid}), 64'b10);
            if (xmsto.aw_valid && xmsti.aw_ready) aw_cnt++;
            if (xmsto.w_valid && xmsti.w_ready) w_cnt++;
            tick();
        end
        xmsti.w_ready  = 1'b0;
        xmsti.aw_ready = 1'b0;
        check("wr1_single_aw_w", 64'({aw_cnt[7:0], w_cnt[7:0]}), 64'h0101);
        check("wr1_wresp_phase", 64'(bus_flags()), 64'b00001);
        xmsti.b_valid = 1'b1;
        xmsti.b_resp  = AXI_RESP_OKAY;
        tick();
        xmsti.b_valid = 1'b0;
        check("wr1_resp", 64'({resp_valid, resp_err}), 64'b10);
        check("wr1_rdata0", resp_rdata, 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Write with AW and W in the same cycle, SLVERR, then a held response.
        issue(1'b1, 32'h28, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        tick();
        req_valid = 1'b0;
        xmsti.aw_ready = 1'b1;
        xmsti.w_ready  = 1'b1;
        tick();
        xmsti.aw_ready = 1'b0;
        xmsti.w_ready  = 1'b0;
        check("wr2_both_done", 64'(bus_flags()), 64'b00001);
        xmsti.b_valid = 1'b1;
        xmsti.b_resp  = AXI_RESP_SLVERR;
        tick();
        xmsti.b_valid = 1'b0;
        xmsti.b_resp  = AXI_RESP_OKAY;
        for (int k = 0; k < 5; k++) begin
            check("wr2_hold", {resp_rdata[59:0], resp_valid, resp_err, req_ready, 1'b0},
                  64'b1100);
            tick();
        end
        resp_ready = 1'b1;
        issue(1'b0, 32'h40, '0, '0);
        tick();
        resp_ready = 1'b0;
        check("b2b_idle_reentry", 64'({req_ready, resp_valid, xmsto.ar_valid}), 64'b100);
        tick();
        req_valid = 1'b0;
        check("b2b_accepted", 64'({xmsto.ar_valid, xmsto.ar_bits.addr}), {31'd0, 1'b1, 32'h40});

        // Reset while waiting for read data.
        xmsti.ar_ready = 1'b1;
        tick();
        xmsti.ar_ready = 1'b0;
        check("rst_pre_rdata", 64'(xmsto.r_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_flags", 64'({req_ready, resp_valid, bus_flags()}), 64'd0);
        tick();
        check("rst_mid_idle", 64'(req_ready), 64'd1);
        do_read("rd2", 32'h0000_0080, 64'h0123_4567_89AB_CDEF);

        // Read whose data never arrives: watchdog aborts.
        issue(1'b0, 32'h100, '0, '0);
        tick();
        req_valid = 1'b0;
        xmsti.ar_ready = 1'b1;
        tick();
        xmsti.ar_ready = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            n++;
            tick();
        end
        check("to_cycles", 64'(n), 64'd16);
        check("to_resp", 64'({resp_valid, resp_err}), 64'b11);
        check("to_rdata0", resp_rdata, 64'd0);
        check("to_bus_idle", 64'(bus_flags()), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("to_back_idle", 64'({req_ready, resp_valid}), 64'b10);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
